// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one sequential signed
// multiplier between NREQ requesters.
//
// Each operation runs through these steps:
//   1. Grant the round-robin winner and latch its operands.
//   2. Pulse Mul_start.
//   3. Wait for Mul_busy to rise, then wait for it to fall.
//   4. Capture Mul_prod and return it with a one-cycle Done pulse.
// A multiplier that never raises Busy, or never drops it, is timed out and the
// operation is returned with Err set.
//
// Ports
//   Clk, Rst   clock, synchronous active-high reset
//   Req        per-requester level request
//   Mpd_in     packed multiplicands, requester i at [i*M_BITS +: M_BITS]
//   Mpr_in     packed multipliers,   requester i at [i*N_BITS +: N_BITS]
//   Gnt        one-hot grant, held from operand latch through Done
//   Done       one-cycle completion pulse to the granted requester
//   Err        timeout flag, valid with Done
//   Prod_out   captured product, held after Done
//   Mul_mpd    operand to multiplier
//   Mul_mpr    operand to multiplier
//   Mul_start  start pulse to multiplier
//   Mul_busy   busy from multiplier
//   Mul_prod   product from multiplier
module mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int M_BITS  = 12,
  parameter int N_BITS  = 8,
  parameter int BUSY_TO = 4,
  parameter int DONE_TO = 64
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NREQ-1:0]          Req,
  input  logic [NREQ*M_BITS-1:0]   Mpd_in,
  input  logic [NREQ*N_BITS-1:0]   Mpr_in,
  output logic [NREQ-1:0]          Gnt,
  output logic [NREQ-1:0]          Done,
  output logic                     Err,
  output logic [M_BITS+N_BITS-1:0] Prod_out,
  output logic [M_BITS-1:0]        Mul_mpd,
  output logic [N_BITS-1:0]        Mul_mpr,
  output logic                     Mul_start,
  input  logic                     Mul_busy,
  input  logic [M_BITS+N_BITS-1:0] Mul_prod
);

  localparam int P_BITS = M_BITS + N_BITS;
  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAX_TO = (BUSY_TO > DONE_TO) ? BUSY_TO : DONE_TO;
  localparam int CNT_W  = $clog2(MAX_TO) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0]    gnt_nxt, done_nxt;
  logic               err_nxt, start_nxt;
  logic [P_BITS-1:0]  prod_nxt;
  logic [M_BITS-1:0]  mpd_nxt, sel_mpd;
  logic [N_BITS-1:0]  mpr_nxt, sel_mpr;
  logic [PTR_W-1:0]   win, idx;
  logic               found;

  // Round-robin search: start one past the last winner and wrap, so the most
  // recently served requester has the lowest priority.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = (idx == PTR_W'(NREQ - 1)) ? '0 : idx + PTR_W'(1);
      if (!found && Req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    sel_mpd = '0;
    sel_mpr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PTR_W'(i)) begin
        sel_mpd = Mpd_in[i*M_BITS +: M_BITS];
        sel_mpr = Mpr_in[i*N_BITS +: N_BITS];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = Gnt;
    done_nxt  = '0;
    err_nxt   = 1'b0;
    start_nxt = 1'b0;
    prod_nxt  = Prod_out;
    mpd_nxt   = Mul_mpd;
    mpr_nxt   = Mul_mpr;
    unique case (state)
      S_IDLE: begin
        // The multiplier is not reset with us, so it may still be finishing
        // an earlier job; never start on top of it.
        if (found && !Mul_busy) begin
          gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << win;
          mpd_nxt   = sel_mpd;
          mpr_nxt   = sel_mpr;
          ptr_nxt   = win;
          state_nxt = S_START;
        end
      end
      S_START: begin
        start_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (Mul_busy) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT_DONE;
        end else if (cnt == CNT_W'(BUSY_TO)) begin
          err_nxt   = 1'b1;
          done_nxt  = Gnt;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!Mul_busy) begin
          prod_nxt  = Mul_prod;
          done_nxt  = Gnt;
          state_nxt = S_DONE;
        end else if (cnt == CNT_W'(DONE_TO)) begin
          err_nxt   = 1'b1;
          done_nxt  = Gnt;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Done and Err are high during this cycle; the grant ends with it.
        gnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      ptr       <= PTR_W'(NREQ - 1);
      cnt       <= '0;
      Gnt       <= '0;
      Done      <= '0;
      Err       <= 1'b0;
      Mul_start <= 1'b0;
      Prod_out  <= '0;
      Mul_mpd   <= '0;
      Mul_mpr   <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      Gnt       <= gnt_nxt;
      Done      <= done_nxt;
      Err       <= err_nxt;
      Mul_start <= start_nxt;
      Prod_out  <= prod_nxt;
      Mul_mpd   <= mpd_nxt;
      Mul_mpr   <= mpr_nxt;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: directed scenarios, a multiplier stand-in, and
// a transaction-level reference model that is compared every cycle.
module tb_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int M_BITS  = 12;
  localparam int N_BITS  = 8;
  localparam int BUSY_TO = 4;
  localparam int DONE_TO = 64;
  localparam int P_BITS  = M_BITS + N_BITS;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [NREQ-1:0] Req = '0;
  logic [M_BITS-1:0] mpd [NREQ];
  logic [N_BITS-1:0] mpr [NREQ];
  logic [NREQ*M_BITS-1:0] Mpd_in;
  logic [NREQ*N_BITS-1:0] Mpr_in;
  logic [NREQ-1:0] Gnt, Done;
  logic Err, Mul_start, Mul_busy;
  logic [P_BITS-1:0] Prod_out, Mul_prod;
  logic [M_BITS-1:0] Mul_mpd;
  logic [N_BITS-1:0] Mul_mpr;

  assign Mpd_in = {mpd[3], mpd[2], mpd[1], mpd[0]};
  assign Mpr_in = {mpr[3], mpr[2], mpr[1], mpr[0]};

  mult_arbiter #(
    .NREQ(NREQ), .M_BITS(M_BITS), .N_BITS(N_BITS),
    .BUSY_TO(BUSY_TO), .DONE_TO(DONE_TO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Mpd_in(Mpd_in), .Mpr_in(Mpr_in),
    .Gnt(Gnt), .Done(Done), .Err(Err), .Prod_out(Prod_out),
    .Mul_mpd(Mul_mpd), .Mul_mpr(Mul_mpr), .Mul_start(Mul_start),
    .Mul_busy(Mul_busy), .Mul_prod(Mul_prod)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [P_BITS-1:0] smul(input logic [M_BITS-1:0] a, input logic [N_BITS-1:0] b);
    logic signed [P_BITS-1:0] ax, bx;
    ax = {{N_BITS{a[M_BITS-1]}}, a};
    bx = {{M_BITS{b[N_BITS-1]}}, b};
    return P_BITS'(ax * bx);
  endfunction

  // Multiplier stand-in: Busy rises the cycle after Start is seen and stays up
  // for 9 cycles. no_busy models a dead multiplier; force_hi holds Busy high.
  logic mbusy = 1'b0;
  int   mcnt = 0;
  logic [P_BITS-1:0] mprod = '0;
  logic no_busy = 1'b0;
  logic force_hi = 1'b0;
  assign Mul_busy = mbusy | force_hi;
  assign Mul_prod = mprod;

  always @(posedge Clk) begin
    if (Mul_start === 1'b1 && !no_busy) begin
      mbusy <= 1'b1;
      mcnt  <= 9;
      mprod <= smul(Mul_mpd, Mul_mpr);
    end else if (mbusy) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mbusy <= 1'b0;
    end
  end

  // Reference model. It tracks one operation as a record. The Done cycle is
  // predicted from the stand-in's known timing:
  //   normal:  Start at s, Busy high s+1..s+9, seen low at s+10, Done at s+11
  //   timeout: Done at s+BUSY_TO+1
  int cyc = 0;
  bit op_active = 0;
  int op_w = 0, op_s = 0, op_done = 0;
  bit op_to = 0;
  logic [P_BITS-1:0] op_prod = '0, exp_prod = '0;
  logic [M_BITS-1:0] exp_mpd = '0;
  logic [N_BITS-1:0] exp_mpr = '0;
  int m_ptr = NREQ - 1;

  always @(posedge Clk) begin : model
    bit f;
    f = 0;
    if (Rst) begin
      op_active = 0;
      m_ptr = NREQ - 1;
      exp_prod = '0;
      exp_mpd = '0;
      exp_mpr = '0;
    end else if (op_active) begin
      if (cyc == op_done) op_active = 0;
    end else if (Req != '0 && Mul_busy == 1'b0) begin
      for (int d = 1; d <= NREQ; d++) begin
        if (!f && Req[(m_ptr + d) % NREQ]) begin
          f = 1;
          op_w = (m_ptr + d) % NREQ;
        end
      end
      m_ptr = op_w;
      op_active = 1;
      op_s = cyc + 2;
      op_to = no_busy;
      op_done = no_busy ? op_s + BUSY_TO + 1 : op_s + 11;
      exp_mpd = mpd[op_w];
      exp_mpr = mpr[op_w];
      op_prod = smul(mpd[op_w], mpr[op_w]);
    end
    cyc++;
    if (op_active && cyc == op_done && !op_to) exp_prod = op_prod;
  end

  // Per-cycle comparison plus logs for the directed literal checks.
  bit chk_en = 0;
  int done_log[$];
  logic [P_BITS-1:0] prod_log[$];
  int err_log[$];
  int start_cyc = -1, done_cyc = -1, n_start = 0;

  always @(negedge Clk) begin : compare
    logic [NREQ-1:0] eg;
    int di;
    if (chk_en) begin
      eg = op_active ? NREQ'(1 << op_w) : '0;
      chk("gnt", 32'(Gnt), 32'(eg));
      chk("done", 32'(Done), (op_active && cyc == op_done) ? 32'(eg) : 32'd0);
      chk("err", 32'(Err), 32'(op_active && cyc == op_done && op_to));
      chk("mul_start", 32'(Mul_start), 32'(op_active && cyc == op_s));
      chk("prod_out", 32'(Prod_out), 32'(exp_prod));
      chk("mul_mpd", 32'(Mul_mpd), 32'(exp_mpd));
      chk("mul_mpr", 32'(Mul_mpr), 32'(exp_mpr));
      if (Mul_start === 1'b1) begin
        start_cyc = cyc;
        n_start++;
      end
      if (Done != '0) begin
        di = -1;
        for (int i = 0; i < NREQ; i++) if (Done[i]) di = i;
        done_log.push_back(di);
        prod_log.push_back(Prod_out);
        err_log.push_back(int'(Err));
        done_cyc = cyc;
      end
    end
  end

  function automatic int dlog(input int i);
    return (i < done_log.size()) ? done_log[i] : -1;
  endfunction
  function automatic logic [P_BITS-1:0] plog(input int i);
    return (i < prod_log.size()) ? prod_log[i] : 'x;
  endfunction
  function automatic int elog(input int i);
    return (i < err_log.size()) ? err_log[i] : -1;
  endfunction

  task automatic clear_logs();
    done_log.delete();
    prod_log.delete();
    err_log.delete();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    Req = '0;
    no_busy = 1'b0;
    force_hi = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k;
    k = 0;
    while (done_log.size() < n && k < budget) begin
      @(negedge Clk);
      k++;
    end
    chk("done_wait", 32'(done_log.size() >= n), 32'd1);
  endtask

  task automatic wait_start(input int n0, input int budget);
    int k;
    k = 0;
    while (n_start <= n0 && k < budget) begin
      @(negedge Clk);
      k++;
    end
    chk("start_wait", 32'(n_start > n0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t_req, n0;
    for (int i = 0; i < NREQ; i++) begin
      mpd[i] = '0;
      mpr[i] = '0;
    end

    // Reset state.
    do_reset();
    chk("rst_gnt", 32'(Gnt), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_start", 32'(Mul_start), 32'd0);
    chk("rst_prod", 32'(Prod_out), 32'd0);
    chk("rst_mpd", 32'(Mul_mpd), 32'd0);
    chk("rst_mpr", 32'(Mul_mpr), 32'd0);
    chk_en = 1;

    // 1: single request, 127 * -127.
    clear_logs();
    mpd[0] = 12'h07F;
    mpr[0] = 8'h81;
    @(negedge Clk);
    Req = 4'b0001;
    t_req = cyc;
    wait_dones(1, 40);
    Req = '0;
    chk("t1_start_latency", 32'(start_cyc - t_req), 32'd2);
    chk("t1_done_latency", 32'(done_cyc - start_cyc), 32'd11);
    chk("t1_prod", 32'(plog(0)), 32'h000FC0FF);
    chk("t1_err", 32'(elog(0)), 32'd0);
    chk("t1_who", 32'(dlog(0)), 32'd0);
    repeat (4) @(negedge Clk);

    // 2: all four requesting, round-robin order and per-requester products.
    do_reset();
    clear_logs();
    mpd[0] = 12'h7FF; mpr[0] = 8'h7F;
    mpd[1] = 12'h800; mpr[1] = 8'h80;
    mpd[2] = 12'hFFF; mpr[2] = 8'h01;
    mpd[3] = 12'h155; mpr[3] = 8'hC3;
    Req = 4'b1111;
    wait_dones(5, 200);
    Req = '0;
    chk("t2_order0", 32'(dlog(0)), 32'd0);
    chk("t2_order1", 32'(dlog(1)), 32'd1);
    chk("t2_order2", 32'(dlog(2)), 32'd2);
    chk("t2_order3", 32'(dlog(3)), 32'd3);
    chk("t2_order4", 32'(dlog(4)), 32'd0);
    chk("t2_prod0", 32'(plog(0)), 32'h0003F781);
    chk("t2_prod1", 32'(plog(1)), 32'h00040000);
    chk("t2_prod2", 32'(plog(2)), 32'h000FFFFF);
    chk("t2_prod3", 32'(plog(3)), 32'h000FAEBF);
    repeat (20) @(negedge Clk);

    // 3: dead multiplier times out, then the next request is served normally.
    do_reset();
    clear_logs();
    no_busy = 1'b1;
    mpd[1] = 12'h010; mpr[1] = 8'h02;
    mpd[2] = 12'h003; mpr[2] = 8'hFE;
    Req = 4'b0010;
    wait_dones(1, 40);
    Req = 4'b0100;
    no_busy = 1'b0;
    chk("t3_to_latency", 32'(done_cyc - start_cyc), 32'd5);
    chk("t3_err", 32'(elog(0)), 32'd1);
    chk("t3_prod_held", 32'(plog(0)), 32'd0);
    wait_dones(2, 40);
    Req = '0;
    chk("t3_next_who", 32'(dlog(1)), 32'd2);
    chk("t3_next_err", 32'(elog(1)), 32'd0);
    chk("t3_next_prod", 32'(plog(1)), 32'h000FFFFA);
    repeat (4) @(negedge Clk);

    // 4: multiplier still busy after reset.
    @(negedge Clk);
    Rst = 1'b1;
    force_hi = 1'b1;
    Req = '0;
    clear_logs();
    mpd[2] = 12'h7FF; mpr[2] = 8'h80;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    Req = 4'b0100;
    n0 = n_start;
    repeat (8) @(negedge Clk);
    chk("t4_no_start", 32'(n_start - n0), 32'd0);
    force_hi = 1'b0;
    wait_dones(1, 40);
    Req = '0;
    chk("t4_who", 32'(dlog(0)), 32'd2);
    chk("t4_prod", 32'(plog(0)), 32'h000C0080);
    repeat (4) @(negedge Clk);

    // 5: reset during WAIT_DONE aborts without Done; request re-served later.
    do_reset();
    clear_logs();
    mpd[0] = 12'h001; mpr[0] = 8'h05;
    n0 = n_start;
    Req = 4'b0001;
    wait_start(n0, 20);
    repeat (4) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("t5_gnt_clr", 32'(Gnt), 32'd0);
    chk("t5_done_clr", 32'(Done), 32'd0);
    chk("t5_start_clr", 32'(Mul_start), 32'd0);
    wait_dones(1, 60);
    Req = '0;
    repeat (20) @(negedge Clk);
    chk("t5_one_done", 32'(done_log.size()), 32'd1);
    chk("t5_who", 32'(dlog(0)), 32'd0);
    chk("t5_prod", 32'(plog(0)), 32'h00000005);

    // 6: granted requester drops Req mid-operation; it still completes.
    do_reset();
    clear_logs();
    mpd[1] = 12'h00A; mpr[1] = 8'h0A;
    mpd[3] = 12'hFF6; mpr[3] = 8'h0A;
    n0 = n_start;
    Req = 4'b1010;
    wait_start(n0, 20);
    repeat (4) @(negedge Clk);
    Req = 4'b1000;
    wait_dones(2, 80);
    Req = '0;
    chk("t6_first", 32'(dlog(0)), 32'd1);
    chk("t6_second", 32'(dlog(1)), 32'd3);
    chk("t6_prod1", 32'(plog(0)), 32'h00000064);
    chk("t6_prod3", 32'(plog(1)), 32'h000FFF9C);
    repeat (4) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
